cart_mbc1: RTL

//  Cartridge-side responder for the LR35902 external bus (a/dout/din/wr/rd).

---
 rtl/cart_mbc1.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cart_mbc1.sv
// MBC1 cartridge mapper: decodes console bus cycles, holds the bank/control
// registers and drives physical ROM/RAM addresses, returning read data one clock later.
module cart_mbc1 #(
    parameter int unsigned ROM_ADDR_W  = 21,
    parameter int unsigned RAM_ADDR_W  = 15,
    parameter int unsigned RAM_PRESENT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           a,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    input  logic                  wr,
    input  logic                  rd,
    output logic [ROM_ADDR_W-1:0] rom_a,
    output logic                  rom_rd,
    input  logic [7:0]            rom_q,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic                  ram_rd,
    output logic                  ram_wr,
    output logic [7:0]            ram_d,
    input  logic [7:0]            ram_q
);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ROM  = 2'd1,
        SEL_RAM  = 2'd2,
        SEL_FF   = 2'd3
    } rd_sel_e;

    localparam logic RAM_OK = (RAM_PRESENT != 0);

    logic       wr_q;
    logic       ram_en_q, ram_en_d;
    logic [4:0] bank1_q, bank1_d;
    logic [1:0] bank2_q, bank2_d;
    logic       mode_q, mode_d;
    rd_sel_e    rd_sel_q, rd_sel_d;
    logic       rd_pend_q;
    logic [7:0] dout_q, dout_d;

    logic       commit;
    logic [2:0] region;
    logic       is_rom, is_ram;
    logic [4:0] bank1_eff;
    logic [6:0] rom_bank;

    assign commit    = wr & ~wr_q;
    assign region    = a[15:13];
    assign is_rom    = ~a[15];
    assign is_ram    = (region == 3'b101);
    assign bank1_eff = (bank1_q == 5'd0) ? 5'd1 : bank1_q;

    // Low window follows bank2 only in mode 1; high window always uses both banks.
    assign rom_bank = a[14] ? {bank2_q, bank1_eff}
                            : (mode_q ? {bank2_q, 5'd0} : 7'd0);
    assign rom_a    = ROM_ADDR_W'({rom_bank, a[13:0]});
    assign ram_a    = RAM_ADDR_W'({(mode_q ? bank2_q : 2'b00), a[12:0]});
    assign ram_d    = din;

    // Strobes are gated by rst so they drop the moment reset asserts.
    assign rom_rd = rst & rd & ~wr & is_rom;
    assign ram_rd = rst & rd & ~wr & is_ram & ram_en_q & RAM_OK;
    assign ram_wr = rst & commit & is_ram & ram_en_q & RAM_OK;
    assign dout   = dout_q;

    always_comb begin
        ram_en_d = ram_en_q;
        bank1_d  = bank1_q;
        bank2_d  = bank2_q;
        mode_d   = mode_q;
        rd_sel_d = rd_sel_q;
        dout_d   = dout_q;

        if (commit) begin
            case (region)
                3'b000:  ram_en_d = (din[3:0] == 4'hA);
                3'b001:  bank1_d  = din[4:0];
                3'b010:  bank2_d  = din[1:0];
                3'b011:  mode_d   = din[0];
                default: ;
            endcase
        end

        if (rd) begin
            if (wr)
                rd_sel_d = SEL_FF;
            else if (is_rom)
                rd_sel_d = SEL_ROM;
            else if (is_ram && ram_en_q && RAM_OK)
                rd_sel_d = SEL_RAM;
            else
                rd_sel_d = SEL_FF;
        end

        // Memory data arrives the clock after the strobe; capture it only for a pending read.
        if (rd_pend_q) begin
            case (rd_sel_q)
                SEL_ROM: dout_d = rom_q;
                SEL_RAM: dout_d = ram_q;
                default: dout_d = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q      <= 1'b0;
            ram_en_q  <= 1'b0;
            bank1_q   <= 5'd0;
            bank2_q   <= 2'd0;
            mode_q    <= 1'b0;
            rd_sel_q  <= SEL_NONE;
            rd_pend_q <= 1'b0;
            dout_q    <= 8'hFF;
        end else begin
            wr_q      <= wr;
            ram_en_q  <= ram_en_d;
            bank1_q   <= bank1_d;
            bank2_q   <= bank2_d;
            mode_q    <= mode_d;
            rd_sel_q  <= rd_sel_d;
            rd_pend_q <= rd;
            dout_q    <= dout_d;
        end
    end

endmodule
